// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces the
// synchronized row pattern and latches the accepted key code with a ready flag.
module keypad_encoder #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] linhas,
  output logic [3:0] colunas,
  output logic [7:0] tecla,
  output logic       ready
);

  localparam int SCW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 2;
  localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_CYCLES - 1);
  localparam logic [SCW-1:0] BLANK_END  = SCW'(2);
  localparam logic [DBW-1:0] PRESS_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  // The PRESSED->DEB_RELEASE edge is itself the first all-high sample.
  localparam logic [DBW-1:0] REL_LAST   = DBW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     sync1_q, sync2_q;
  logic [1:0]     col_q, col_d;
  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DBW-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]     cap_q, cap_d;
  logic [7:0]     tecla_q, tecla_d;
  logic           ready_q, ready_d;
  logic [3:0]     rows_s;

  function automatic logic [1:0] low_row(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  function automatic logic [7:0] key_code(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'b00_00: return 8'd1;
      4'b00_01: return 8'd2;
      4'b00_10: return 8'd3;
      4'b00_11: return 8'd10;
      4'b01_00: return 8'd4;
      4'b01_01: return 8'd5;
      4'b01_10: return 8'd6;
      4'b01_11: return 8'd11;
      4'b10_00: return 8'd7;
      4'b10_01: return 8'd8;
      4'b10_10: return 8'd9;
      4'b10_11: return 8'd12;
      4'b11_00: return 8'd13;
      4'b11_01: return 8'd0;
      4'b11_10: return 8'd14;
      default:  return 8'd15;
    endcase
  endfunction

  assign rows_s  = sync2_q;
  assign colunas = ~(4'b0001 << col_q);
  assign tecla   = tecla_q;
  assign ready   = ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 4'h0;
      sync2_q    <= 4'h0;
      state_q    <= SCAN;
      col_q      <= 2'd0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      cap_q      <= 4'hF;
      tecla_q    <= 8'hFF;
      ready_q    <= 1'b0;
    end else begin
      sync1_q    <= linhas;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      col_q      <= col_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      cap_q      <= cap_d;
      tecla_q    <= tecla_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    cap_d      = cap_q;
    tecla_d    = tecla_q;
    ready_d    = ready_q;
    case (state_q)
      SCAN: begin
        // The synchronizer still holds the previous column's rows for two clocks.
        if (scan_cnt_q >= BLANK_END && rows_s != 4'hF) begin
          state_d   = DEB_PRESS;
          cap_d     = rows_s;
          deb_cnt_d = '0;
        end else if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          col_d      = col_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + SCW'(1);
        end
      end
      DEB_PRESS: begin
        if (rows_s == cap_q) begin
          if (deb_cnt_q == PRESS_LAST) begin
            state_d   = PRESSED;
            tecla_d   = key_code(low_row(cap_q), col_q);
            ready_d   = 1'b1;
            deb_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + DBW'(1);
          end
        end else begin
          state_d    = SCAN;
          deb_cnt_d  = '0;
          scan_cnt_d = '0;
        end
      end
      PRESSED: begin
        if (rows_s == 4'hF) begin
          state_d   = DEB_RELEASE;
          deb_cnt_d = '0;
        end
      end
      DEB_RELEASE: begin
        if (rows_s != 4'hF) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == REL_LAST) begin
          state_d    = SCAN;
          ready_d    = 1'b0;
          deb_cnt_d  = '0;
          scan_cnt_d = '0;
          col_d      = col_q + 2'd1;
        end else begin
          deb_cnt_d = deb_cnt_q + DBW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 The module SHALL have parameter SCAN_CYCLES, default 1000, meaning clocks each column stays driven during scanning (minimum 4).
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 20000, meaning consecutive stable synchronized samples required to accept a press or a release (minimum 2).
REQ-003 The module SHALL have port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 The module SHALL have port linhas  input  4  keypad row lines, active-low (pulled up), asynchronous to clk.
REQ-006 The module SHALL have port colunas  output  4  keypad column drive, one-hot active-low.
REQ-007 The module SHALL have port tecla  output  8  code of the last accepted key.
REQ-008 The module SHALL have port ready  output  1  high while the accepted key is held.

Function
REQ-009 The module SHALL pass linhas through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-010 The module SHALL map key (row r, column c) to codes as follows: r0: 1,2,3,10(+); r1: 4,5,6,11(-); r2: 7,8,9,12(STO); r3: 13(RCL),0,14(=),15(CLR).
REQ-011 The module SHALL implement FSM states SCAN, DEB_PRESS, PRESSED, DEB_RELEASE.
REQ-012 In SCAN, colunas SHALL rotate 1110->1101->1011->0111->1110, advancing every SCAN_CYCLES clocks.
REQ-013 In SCAN, row detection SHALL be blanked for the first 2 clocks after each column change.
REQ-014 SCAN->DEB_PRESS SHALL occur when the synchronized rows are not 4'b1111 outside blanking; column and row pattern are captured and colunas is frozen.
REQ-015 In DEB_PRESS, each clock whose synchronized pattern equals the captured pattern SHALL increment the debounce counter.
REQ-016 In DEB_PRESS, any differing pattern SHALL return the FSM to SCAN with the counter cleared and rotation resuming from the frozen column.
REQ-017 When the counter reaches DEBOUNCE_CYCLES-1 with the pattern still equal, on the same edge tecla SHALL load the mapped code, ready SHALL go 1, and the FSM SHALL go to PRESSED.
REQ-018 Press latency SHALL be exactly DEBOUNCE_CYCLES+3 clocks from a linhas change (with column already stable) to ready rising.
REQ-019 If several rows are low in the frozen column, the lowest-numbered row SHALL win.
REQ-020 Keys in other columns SHALL be ignored until release completes.
REQ-021 In PRESSED, colunas SHALL stay frozen; synchronized rows equal to 4'b1111 SHALL cause entry to DEB_RELEASE with the counter cleared.
REQ-022 In DEB_RELEASE, DEBOUNCE_CYCLES consecutive all-high samples SHALL clear ready on the final edge and return the FSM to SCAN at the next column.
REQ-023 In DEB_RELEASE, any low row SHALL return the FSM to PRESSED with ready kept at 1 and tecla unchanged.
REQ-024 tecla SHALL hold its value after release until the next accepted press; consumers sample it while ready is 0.
REQ-025 tecla and ready SHALL change only on the same edge; there SHALL be no single-cycle glitches.

Reset
REQ-026 Asserting reset SHALL immediately force state SCAN, colunas=4'b1110, tecla=8'hFF (matches no valid code), ready=0, and clear all counters and synchronizer flops.
REQ-027 Reset asserted mid-press or mid-debounce SHALL abandon that key; after release of reset, a still-held key SHALL be re-detected and fully re-debounced.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-028 Bench: reset, no keys -> tecla=8'hFF, ready=0, colunas cycling 1110,1101,1011,0111 every 4 clocks.
REQ-029 Bench: hold row1/col2 ('6') stable -> ready rises 11 clocks after linhas changes (while col2 is driven), tecla=6; release -> ready falls 8 clocks after synchronized rows go high, tecla stays 6.
REQ-030 Bench: row3/col2 ('=') bouncing 3 clocks low, 2 high, then stable low -> exactly one ready rise, tecla=14, no earlier assertion.
REQ-031 Bench: hold '+' (row0/col3), then glitch rows high for 3 clocks -> ready stays 1 throughout, tecla=10.
REQ-032 Bench: rows 1 and 2 low together in col0 -> tecla=4; additionally pressing '9' while '4' held -> ignored, tecla remains 4.
REQ-033 Bench: assert reset at debounce count 5 of a press -> ready=0, tecla=8'hFF immediately; key still held after reset -> accepted after a full re-debounce.
